sync_fifo: RTL and testbench

Single-clock, parametrised FIFO; the next-generation successor to the dual-clock FIFO for paths where producer and consumer share one clock domain. Adds programmable almost-full/almost-empty thresholds, an occupancy count, a selectable first-word-fall-through (FWFT) read mode, a read-valid strobe, and sticky overflow/underflow error flags. Sits between same-clock pipeline stages as an elastic buffer and rate decoupler.

---
 rtl/sync_fifo.sv | 185 ++++++++++++++++++
 tb/tb_sync_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, selectable standard or first-word-fall-through read port and sticky error flags.

module sync_fifo_chk #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] count,
  input logic          w_full,
  input logic          r_empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);
  a_full_flag:   assert property (@(posedge clk) disable iff (rst) w_full == (count == DEPTH_C));
  a_empty_flag:  assert property (@(posedge clk) disable iff (rst) r_empty == (count == ZERO_C));

endmodule

module sync_fifo #(
  parameter int WIDTH     = 5,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic [WIDTH-1:0]           i_dat,
  output logic                       w_full,
  output logic                       w_almost_full,
  output logic                       w_overflow,
  input  logic                       r_en,
  output logic [WIDTH-1:0]           o_dat,
  output logic                       o_valid,
  output logic                       r_empty,
  output logic                       r_almost_empty,
  output logic                       r_underflow,
  input  logic                       err_clr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]    AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0]    AE_C     = CW'(AE_THRESH);
  localparam logic [CW-1:0]    C_ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0]    C_ONE_C  = CW'(1);
  localparam logic [AW-1:0]    P_ZERO_C = {AW{1'b0}};
  localparam logic [AW-1:0]    P_ONE_C  = AW'(1);
  localparam logic [WIDTH-1:0] D_ZERO_C = {WIDTH{1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             afull_r;
  logic             aempty_r;
  logic             ovf_r;
  logic             unf_r;
  logic             wr_acc_s;
  logic             rd_acc_s;

  // Acceptance looks only at this cycle's registered flags, never at the opposite port.
  assign wr_acc_s = w_en & ~full_r;
  assign rd_acc_s = r_en & ~empty_r;

  // Next occupancy: a simultaneous accepted read and write cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + C_ONE_C;
      2'b01:   count_nxt_s = count_r - C_ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count and status flags; flags follow the next count so they always agree with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= P_ZERO_C;
      rd_ptr_r <= P_ZERO_C;
      count_r  <= C_ZERO_C;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + P_ONE_C;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + P_ONE_C;
      end
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == DEPTH_C);
      empty_r  <= (count_nxt_s == C_ZERO_C);
      afull_r  <= (count_nxt_s >= AF_C);
      aempty_r <= (count_nxt_s <= AE_C);
    end
  end

  // Storage array; not reset, and reset blocks any write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_s) begin
      mem_r[wr_ptr_r] <= i_dat;
    end
  end

  // Sticky error flags; a new offence wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (w_en && full_r) begin
        ovf_r <= 1'b1;
      end else if (err_clr) begin
        ovf_r <= 1'b0;
      end
      if (r_en && empty_r) begin
        unf_r <= 1'b1;
      end else if (err_clr) begin
        unf_r <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; forced to zero while empty so stale storage never shows.
      assign o_dat   = empty_r ? D_ZERO_C : mem_r[rd_ptr_r];
      assign o_valid = ~empty_r;
    end else begin : g_std
      logic [WIDTH-1:0] rd_dat_r;
      logic             rd_vld_r;

      // Registered read port: data lands the cycle after the accepting edge and then holds.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_dat_r <= D_ZERO_C;
          rd_vld_r <= 1'b0;
        end else begin
          rd_vld_r <= rd_acc_s;
          if (rd_acc_s) begin
            rd_dat_r <= mem_r[rd_ptr_r];
          end
        end
      end

      assign o_dat   = rd_dat_r;
      assign o_valid = rd_vld_r;
    end
  endgenerate

  assign count          = count_r;
  assign w_full         = full_r;
  assign w_almost_full  = afull_r;
  assign w_overflow     = ovf_r;
  assign r_empty        = empty_r;
  assign r_almost_empty = aempty_r;
  assign r_underflow    = unf_r;

  sync_fifo_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .count   (count_r),
    .w_full  (full_r),
    .r_empty (empty_r)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: one standard-mode and one FWFT instance, directed stimulus
// with hand-computed expectations; monitors pop the expected-data queues when words are presented.

module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en, r_en, err_clr;
  logic [4:0] i_dat;
  logic       w_full, w_almost_full, w_overflow;
  logic [4:0] o_dat;
  logic       o_valid, r_empty, r_almost_empty, r_underflow;
  logic [4:0] count;

  logic       f_w_en, f_r_en, f_err_clr;
  logic [4:0] f_i_dat;
  logic       f_w_full, f_w_almost_full, f_w_overflow;
  logic [4:0] f_o_dat;
  logic       f_o_valid, f_r_empty, f_r_almost_empty, f_r_underflow;
  logic [4:0] f_count;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q[$];
  logic [4:0] mq[$];
  logic [4:0] f_exp[$];

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(5), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .i_dat(i_dat), .w_full(w_full),
    .w_almost_full(w_almost_full), .w_overflow(w_overflow), .r_en(r_en), .o_dat(o_dat),
    .o_valid(o_valid), .r_empty(r_empty), .r_almost_empty(r_almost_empty),
    .r_underflow(r_underflow), .err_clr(err_clr), .count(count)
  );

  sync_fifo #(.WIDTH(5), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(f_w_en), .i_dat(f_i_dat), .w_full(f_w_full),
    .w_almost_full(f_w_almost_full), .w_overflow(f_w_overflow), .r_en(f_r_en), .o_dat(f_o_dat),
    .o_valid(f_o_valid), .r_empty(f_r_empty), .r_almost_empty(f_r_almost_empty),
    .r_underflow(f_r_underflow), .err_clr(f_err_clr), .count(f_count)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One standard-port cycle; the queue model decides acceptance from pre-edge occupancy.
  task automatic cyc(input logic w, input logic [4:0] d, input logic r, input logic c);
    bit wacc, racc;
    w_en = w; i_dat = d; r_en = r; err_clr = c;
    if (rst) begin
      mq.delete();
    end else begin
      wacc = w && (mq.size() < 16);
      racc = r && (mq.size() > 0);
      if (racc) exp_q.push_back(mq.pop_front());
      if (wacc) mq.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  task automatic fcyc(input logic w, input logic [4:0] d, input logic r);
    f_w_en = w; f_i_dat = d; f_r_en = r;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"},    int'(count), 0);
    chk({tag, "_empty"},    int'(r_empty), 1);
    chk({tag, "_aempty"},   int'(r_almost_empty), 1);
    chk({tag, "_full"},     int'(w_full), 0);
    chk({tag, "_afull"},    int'(w_almost_full), 0);
    chk({tag, "_valid"},    int'(o_valid), 0);
    chk({tag, "_odat"},     int'(o_dat), 0);
    chk({tag, "_ovf"},      int'(w_overflow), 0);
    chk({tag, "_unf"},      int'(r_underflow), 0);
    chk({tag, "_f_count"},  int'(f_count), 0);
    chk({tag, "_f_valid"},  int'(f_o_valid), 0);
  endtask

  always @(negedge clk) begin : mon_std
    logic [4:0] e;
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL std_unexpected: got o_dat=%0d with o_valid, expected no word (t=%0t)", o_dat, $time);
      end else begin
        e = exp_q.pop_front();
        chk("std_o_dat", int'(o_dat), int'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_fwft
    logic [4:0] e;
    if (f_o_valid && f_r_en) begin
      if (f_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fwft_unexpected: got o_dat=%0d popped, expected no word (t=%0t)", f_o_dat, $time);
      end else begin
        e = f_exp.pop_front();
        chk("fwft_o_dat", int'(f_o_dat), int'(e));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; i_dat = 5'd0;
    f_w_en = 1'b0; f_r_en = 1'b0; f_err_clr = 1'b0; f_i_dat = 5'd0;
    cyc(1'b0, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0);
    chk_reset("rst0");
    rst = 1'b0;

    // Overfill: 21 writes of i+7, only the first 16 land.
    for (int i = 0; i < 21; i++) begin
      cyc(1'b1, 5'(i + 7), 1'b0, 1'b0);
      n = (i + 1 < 16) ? i + 1 : 16;
      chk("fill_count", int'(count), n);
      chk("fill_afull", int'(w_almost_full), (n >= 14) ? 1 : 0);
      chk("fill_full",  int'(w_full), (n == 16) ? 1 : 0);
      chk("fill_ovf",   int'(w_overflow), (i >= 16) ? 1 : 0);
    end

    // Drain: 7..22 in order, then underflow with o_dat holding 22.
    for (int i = 0; i < 21; i++) begin
      cyc(1'b0, 5'd0, 1'b1, 1'b0);
      n = (15 - i > 0) ? 15 - i : 0;
      chk("drain_count",  int'(count), n);
      chk("drain_aempty", int'(r_almost_empty), (n <= 2) ? 1 : 0);
      chk("drain_empty",  int'(r_empty), (n == 0) ? 1 : 0);
      chk("drain_unf",    int'(r_underflow), (i >= 16) ? 1 : 0);
      chk("drain_valid",  int'(o_valid), (i < 16) ? 1 : 0);
      chk("drain_odat",   int'(o_dat), (i < 16) ? i + 7 : 22);
    end

    cyc(1'b0, 5'd0, 1'b0, 1'b1);
    chk("clr_ovf", int'(w_overflow), 0);
    chk("clr_unf", int'(r_underflow), 0);

    // Steady state at count 8 with simultaneous read/write across pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1'b1, 5'(i), 1'b0, 1'b0);
    chk("pre_rw_count", int'(count), 8);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 5'(i + 8), 1'b1, 1'b0);
      chk("rw_count", int'(count), 8);
      chk("rw_odat",  int'(o_dat), i % 32);
    end

    // Fill to 16, then read+write while full: read wins, write rejected.
    for (int i = 0; i < 8; i++) cyc(1'b1, 5'(i + 20), 1'b0, 1'b0);
    chk("full16_count", int'(count), 16);
    chk("full16_full",  int'(w_full), 1);
    cyc(1'b1, 5'd1, 1'b1, 1'b0);
    chk("both_full_count", int'(count), 15);
    chk("both_full_ovf",   int'(w_overflow), 1);
    chk("both_full_valid", int'(o_valid), 1);

    cyc(1'b0, 5'd0, 1'b0, 1'b1);
    chk("clr2_ovf", int'(w_overflow), 0);
    cyc(1'b1, 5'd2, 1'b0, 1'b0);
    chk("refill_count", int'(count), 16);
    chk("refill_ovf",   int'(w_overflow), 0);
    cyc(1'b1, 5'd3, 1'b0, 1'b1);
    chk("set_vs_clr_ovf", int'(w_overflow), 1);
    chk("set_vs_clr_count", int'(count), 16);

    // Reset mid-traffic with both requests asserted.
    rst = 1'b1;
    cyc(1'b1, 5'd9, 1'b1, 1'b0);
    cyc(1'b1, 5'd9, 1'b1, 1'b0);
    chk_reset("rst1");
    rst = 1'b0;
    cyc(1'b1, 5'd11, 1'b0, 1'b0);
    chk("post_rst_count", int'(count), 1);
    cyc(1'b0, 5'd0, 1'b1, 1'b0);
    chk("post_rst_odat", int'(o_dat), 11);
    cyc(1'b0, 5'd0, 1'b0, 1'b0);
    chk("post_rst_empty", int'(r_empty), 1);
    chk("std_queue_left", exp_q.size(), 0);

    // FWFT: 3 visible one cycle after its write; pops present 5 then 9.
    fcyc(1'b1, 5'd3, 1'b0);
    chk("fwft_first_valid", int'(f_o_valid), 1);
    chk("fwft_first_odat",  int'(f_o_dat), 3);
    fcyc(1'b1, 5'd5, 1'b0);
    fcyc(1'b1, 5'd9, 1'b0);
    chk("fwft_count", int'(f_count), 3);
    f_exp.push_back(5'd3);
    f_exp.push_back(5'd5);
    f_exp.push_back(5'd9);
    fcyc(1'b0, 5'd0, 1'b1);
    chk("fwft_after_pop1", int'(f_o_dat), 5);
    fcyc(1'b0, 5'd0, 1'b1);
    chk("fwft_after_pop2", int'(f_o_dat), 9);
    fcyc(1'b0, 5'd0, 1'b1);
    chk("fwft_empty", int'(f_r_empty), 1);
    chk("fwft_valid_low", int'(f_o_valid), 0);
    fcyc(1'b0, 5'd0, 1'b1);
    chk("fwft_unf", int'(f_r_underflow), 1);
    fcyc(1'b0, 5'd0, 1'b0);
    chk("fwft_queue_left", f_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
